frame_receiver: RTL and testbench

FRAME_RECEIVER -- requirements
Module: frame_receiver

---
 rtl/frame_receiver_pkg.sv | 17 +
 rtl/frame_receiver_if.sv | 26 ++
 rtl/frame_receiver_word_packer.sv | 47 ++++
 rtl/frame_receiver.sv | 140 ++++++++++++++
 tb/tb_frame_receiver.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/frame_receiver_pkg.sv
// Shared frame-format constants and FSM encoding for the UART frame receiver
// and the thread that writes frames over the UART.
package frame_receiver_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      COUNT  = 3'd1,
      HEADER = 3'd2,
      DATA   = 3'd3,
      DRAIN  = 3'd4
   } state_t;

   localparam int COUNT_BYTES  = 4;
   localparam int HEADER_BYTES = 1;
   localparam int ADDR_SHIFT   = 8;

endpackage

// File: rtl/frame_receiver_if.sv
// Byte stream in, word-write bus and frame status out.
interface frame_receiver_if #(
   parameter int BITWIDTH = 32
);
   logic [7:0]          read_data;
   logic                read_data_valid;
   logic                mem_wr_en;
   logic [BITWIDTH-1:0] mem_wr_addr;
   logic [BITWIDTH-1:0] mem_wr_data;
   logic                frame_done;
   logic                frame_error;
   logic [7:0]          frame_header;
   logic                busy;

   modport slave (
      input  read_data, read_data_valid,
      output mem_wr_en, mem_wr_addr, mem_wr_data,
      output frame_done, frame_error, frame_header, busy
   );

   modport master (
      output read_data, read_data_valid,
      input  mem_wr_en, mem_wr_addr, mem_wr_data,
      input  frame_done, frame_error, frame_header, busy
   );
endinterface

// File: rtl/frame_receiver_word_packer.sv
// Little-endian byte-to-word assembler; a byte flagged last flushes a
// zero-padded partial word.
module word_packer #(
   parameter int BITWIDTH = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   input  logic                byte_valid,
   input  logic [7:0]          byte_data,
   input  logic                last,
   output logic                word_valid,
   output logic [BITWIDTH-1:0] word_data
);

   logic [1:0]          lane;
   logic [BITWIDTH-1:0] acc;
   logic [BITWIDTH-1:0] merged;

   assign merged = acc | (BITWIDTH'(byte_data) << {lane, 3'b000});

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lane       <= '0;
         acc        <= '0;
         word_valid <= 1'b0;
         word_data  <= '0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            lane <= '0;
            acc  <= '0;
         end else if (byte_valid) begin
            if (lane == 2'd3 || last) begin
               word_valid <= 1'b1;
               word_data  <= merged;
               lane       <= '0;
               acc        <= '0;
            end else begin
               acc  <= merged;
               lane <= lane + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/frame_receiver.sv
// UART frame receiver: 4-byte LE count, header byte, payload packed into
// words written at (header << 8) + word_index.
//
// state  | meaning
// IDLE   | waiting for count byte 0
// COUNT  | collecting count bytes 1..3
// HEADER | waiting for header byte
// DATA   | payload bytes, words written via word_packer
// DRAIN  | discarding a rejected frame's announced bytes
module frame_receiver
   import frame_receiver_pkg::*;
#(
   parameter int BITWIDTH = 32,
   parameter int MAXWORDS = 256,
   parameter int TIMEOUT  = 1024
) (
   input  logic             clock,
   input  logic             reset,
   frame_receiver_if.slave  bus
);

   localparam logic [31:0] MAX_COUNT = 32'(1 + 4 * MAXWORDS);

   state_t              state;
   logic [1:0]          cnt_idx;
   logic [23:0]         cnt_lo;
   logic [31:0]         rem;
   logic [31:0]         timer;
   logic [7:0]          header;
   logic [BITWIDTH-1:0] word_idx;
   logic                done;
   logic                error;
   logic                word_valid;
   logic [BITWIDTH-1:0] word_data;
   logic [31:0]         full_count;

   assign full_count = {bus.read_data, cnt_lo};

   word_packer #(.BITWIDTH(BITWIDTH)) u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      (bus.read_data_valid && state == HEADER),
      .byte_valid (bus.read_data_valid && state == DATA),
      .byte_data  (bus.read_data),
      .last       (rem == 32'd1),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt_idx  <= '0;
         cnt_lo   <= '0;
         rem      <= '0;
         timer    <= '0;
         header   <= '0;
         word_idx <= '0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         if (word_valid)
            word_idx <= word_idx + BITWIDTH'(1);

         // idle-cycle timer: reloaded on every byte, counts down otherwise
         if (bus.read_data_valid) begin
            timer <= 32'(TIMEOUT);
         end else if (state != IDLE) begin
            if (timer <= 32'd1) begin
               error <= 1'b1;
               state <= IDLE;
            end else begin
               timer <= timer - 32'd1;
            end
         end

         if (bus.read_data_valid) begin
            case (state)
               IDLE: begin
                  cnt_lo[7:0] <= bus.read_data;
                  cnt_idx     <= 2'd1;
                  state       <= COUNT;
               end
               COUNT: begin
                  if (cnt_idx == 2'(COUNT_BYTES - 1)) begin
                     if (full_count == 32'd0) begin
                        error <= 1'b1;
                        state <= IDLE;
                     end else if (full_count > MAX_COUNT) begin
                        error <= 1'b1;
                        rem   <= full_count;
                        state <= DRAIN;
                     end else begin
                        rem   <= full_count - 32'(HEADER_BYTES);
                        state <= HEADER;
                     end
                  end else begin
                     cnt_lo[{cnt_idx, 3'b000} +: 8] <= bus.read_data;
                     cnt_idx <= cnt_idx + 2'd1;
                  end
               end
               HEADER: begin
                  header   <= bus.read_data;
                  word_idx <= '0;
                  if (rem == 32'd0) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  rem <= rem - 32'd1;
                  if (rem == 32'd1) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
               DRAIN: begin
                  rem <= rem - 32'd1;
                  if (rem == 32'd1)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.mem_wr_en    = word_valid;
   assign bus.mem_wr_data  = word_data;
   assign bus.mem_wr_addr  = (BITWIDTH'(header) << ADDR_SHIFT) + word_idx;
   assign bus.frame_done   = done;
   assign bus.frame_error  = error;
   assign bus.frame_header = header;
   assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: good frames, partial word, reject/drain,
// timeout, mid-frame reset and back-to-back frames.
module tb_frame_receiver;

   localparam int TIMEOUT = 1024;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   frame_receiver_if #(.BITWIDTH(32)) bus ();

   frame_receiver #(.BITWIDTH(32), .MAXWORDS(256), .TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // write / pulse log captured on the falling edge
   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];
   logic        wr_done [64];
   int n_wr   = 0;
   int n_done = 0;
   int n_err  = 0;

   always @(negedge clock) begin
      if (bus.mem_wr_en) begin
         if (n_wr < 64) begin
            wr_addr[n_wr] = bus.mem_wr_addr;
            wr_data[n_wr] = bus.mem_wr_data;
            wr_done[n_wr] = bus.frame_done;
         end
         n_wr = n_wr + 1;
      end
      if (bus.frame_done)  n_done = n_done + 1;
      if (bus.frame_error) n_err  = n_err + 1;
   end

   logic [7:0] q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      @(negedge clock);
      bus.read_data       = b;
      bus.read_data_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         bus.read_data_valid = 1'b0;
      end
   endtask

   task automatic send_q(input int gap);
      foreach (q[i]) begin
         put(q[i]);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_en"},  32'(bus.mem_wr_en),    32'h0);
      check({tag, "_addr"},   bus.mem_wr_addr,       32'h0);
      check({tag, "_data"},   bus.mem_wr_data,       32'h0);
      check({tag, "_done"},   32'(bus.frame_done),   32'h0);
      check({tag, "_err"},    32'(bus.frame_error),  32'h0);
      check({tag, "_header"}, 32'(bus.frame_header), 32'h0);
      check({tag, "_busy"},   32'(bus.busy),         32'h0);
   endtask

   int b_wr, b_done, b_err, k;

   initial begin
      reset               = 1'b0;
      bus.read_data       = 8'h00;
      bus.read_data_valid = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_outputs("rst");
      reset = 1'b1;
      idle(2);

      // 9-byte count, header 03, two full words, bytes spaced out
      b_wr = n_wr; b_done = n_done; b_err = n_err;
      q = '{8'h09, 8'h00, 8'h00, 8'h00, 8'h03,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_q(1);
      idle(3);
      check("f1_nwr",   32'(n_wr - b_wr), 32'd2);
      check("f1_addr0", wr_addr[b_wr],     32'h0000_0300);
      check("f1_data0", wr_data[b_wr],     32'h4433_2211);
      check("f1_done0", 32'(wr_done[b_wr]), 32'd0);
      check("f1_addr1", wr_addr[b_wr+1],   32'h0000_0301);
      check("f1_data1", wr_data[b_wr+1],   32'h8877_6655);
      check("f1_done1", 32'(wr_done[b_wr+1]), 32'd1);
      check("f1_ndone", 32'(n_done - b_done), 32'd1);
      check("f1_nerr",  32'(n_err - b_err),   32'd0);
      check("f1_hdr",   32'(bus.frame_header), 32'h03);
      check("f1_busy",  32'(bus.busy),         32'd0);

      // partial final word, immediately followed by a header-only frame
      b_wr = n_wr; b_done = n_done; b_err = n_err;
      q = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h01,
            8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
            8'h01, 8'h00, 8'h00, 8'h00, 8'h7F};
      send_q(0);
      idle(3);
      check("f2_nwr",   32'(n_wr - b_wr), 32'd2);
      check("f2_addr0", wr_addr[b_wr],     32'h0000_0100);
      check("f2_data0", wr_data[b_wr],     32'hDDCC_BBAA);
      check("f2_addr1", wr_addr[b_wr+1],   32'h0000_0101);
      check("f2_data1", wr_data[b_wr+1],   32'h0000_00EE);
      check("f2_done1", 32'(wr_done[b_wr+1]), 32'd1);
      check("f3_ndone", 32'(n_done - b_done), 32'd2);
      check("f3_nerr",  32'(n_err - b_err),   32'd0);
      check("f3_hdr",   32'(bus.frame_header), 32'h7F);

      // oversize count 0x402: error, drain exactly 0x402 bytes, then a good frame
      b_wr = n_wr; b_done = n_done; b_err = n_err;
      q = '{8'h02, 8'h04, 8'h00, 8'h00};
      send_q(0);
      for (int i = 0; i < 'h401; i++) put(8'(i));
      idle(1);
      check("drain_err",   32'(n_err - b_err), 32'd1);
      check("drain_busy1", 32'(bus.busy),      32'd1);
      put(8'h5A);
      idle(1);
      check("drain_busy0", 32'(bus.busy),      32'd0);
      check("drain_nwr",   32'(n_wr - b_wr),   32'd0);
      check("drain_ndone", 32'(n_done - b_done), 32'd0);
      q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
      send_q(0);
      idle(3);
      check("post_nwr",  32'(n_wr - b_wr),   32'd1);
      check("post_addr", wr_addr[b_wr],       32'h0000_0200);
      check("post_data", wr_data[b_wr],       32'h0403_0201);
      check("post_done", 32'(wr_done[b_wr]),  32'd1);

      // timeout after 5 of 8 payload bytes
      b_wr = n_wr; b_done = n_done; b_err = n_err;
      q = '{8'h09, 8'h00, 8'h00, 8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_q(0);
      k = 0;
      for (int i = 1; i <= TIMEOUT + 10; i++) begin
         @(negedge clock);
         bus.read_data_valid = 1'b0;
         k = i;
         if (bus.frame_error) break;
      end
      check("to_err_seen", 32'(bus.frame_error), 32'd1);
      check("to_latency",  32'(k),               32'(TIMEOUT + 1));
      idle(4);
      check("to_nwr",  32'(n_wr - b_wr),   32'd1);
      check("to_addr", wr_addr[b_wr],       32'h0000_0500);
      check("to_data", wr_data[b_wr],       32'h0403_0201);
      check("to_nerr", 32'(n_err - b_err),  32'd1);
      check("to_ndone", 32'(n_done - b_done), 32'd0);
      check("to_busy", 32'(bus.busy),       32'd0);

      // reset after the 2nd payload byte, then a full frame from word 0
      q = '{8'h09, 8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22};
      send_q(0);
      @(negedge clock);
      bus.read_data_valid = 1'b0;
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      idle(2);
      reset = 1'b1;
      idle(2);
      b_wr = n_wr; b_done = n_done; b_err = n_err;
      q = '{8'h09, 8'h00, 8'h00, 8'h00, 8'h04,
            8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
      send_q(0);
      idle(3);
      check("rf_nwr",   32'(n_wr - b_wr),   32'd2);
      check("rf_addr0", wr_addr[b_wr],       32'h0000_0400);
      check("rf_data0", wr_data[b_wr],       32'hA4A3_A2A1);
      check("rf_addr1", wr_addr[b_wr+1],     32'h0000_0401);
      check("rf_data1", wr_data[b_wr+1],     32'hA8A7_A6A5);
      check("rf_nerr",  32'(n_err - b_err),  32'd0);
      check("rf_ndone", 32'(n_done - b_done), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
